ps2_rx_fifo: RTL

//  Parametrised PS/2 device-to-host receiver with a configurable-depth first-word-fall-through (FWFT) FIFO.

---
 rtl/ps2_rx_fifo.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the pins, checks each 11-bit frame,
// optionally folds E0/F0 prefixes into key events, and queues results in a FWFT FIFO.
module ps2_rx_fifo #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 50000,
  parameter int DECODE      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     rd_en,
  output logic [9:0]               data,
  output logic                     ready,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     parity_err,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   prev_clk_r;
  logic                   sync_clk_s;
  logic                   sync_data_s;
  logic                   fall_s;

  logic [3:0]    bit_cnt_r;
  logic [9:0]    shift_r;
  logic [WW-1:0] wd_r;
  logic          ext_r;
  logic          brk_r;
  logic          ext_nxt_s;
  logic          brk_nxt_s;
  logic          parity_err_r;
  logic          frame_err_r;

  logic          frame_done_s;
  logic          framing_bad_s;
  logic          parity_bad_s;
  logic          accept_s;
  logic          timeout_s;
  logic [7:0]    byte_s;
  logic          push_s;
  logic [9:0]    push_data_s;

  logic [9:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          overflow_r;
  logic          pop_s;
  logic          do_write_s;

  // Pin synchronisers; they keep tracking the pins through reset so no false edge appears on release.
  always_ff @(posedge clk) begin
    clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
    data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
    prev_clk_r  <= clk_sync_r[SYNC_STAGES-1];
  end

  assign sync_clk_s  = clk_sync_r[SYNC_STAGES-1];
  assign sync_data_s = data_sync_r[SYNC_STAGES-1];
  assign fall_s      = prev_clk_r & ~sync_clk_s;

  // shift_r holds start at [0], d0..d7 at [8:1], parity at [9]; the stop bit is judged live.
  assign frame_done_s  = fall_s & (bit_cnt_r == 4'd10);
  assign framing_bad_s = shift_r[0] | ~sync_data_s;
  assign parity_bad_s  = ~(^shift_r[9:1]);
  assign accept_s      = frame_done_s & ~framing_bad_s & ~parity_bad_s;
  assign timeout_s     = ~fall_s & (bit_cnt_r != 4'd0) & (wd_r == WD_LAST);
  assign byte_s        = shift_r[8:1];

  // Prefix decoding and push request for an accepted frame.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = {2'b00, byte_s};
    ext_nxt_s   = ext_r;
    brk_nxt_s   = brk_r;
    if (accept_s) begin
      if (DECODE != 0) begin
        if (byte_s == 8'hE0) begin
          ext_nxt_s = 1'b1;
        end else if (byte_s == 8'hF0) begin
          brk_nxt_s = 1'b1;
        end else begin
          push_s      = 1'b1;
          push_data_s = {ext_r, brk_r, byte_s};
          ext_nxt_s   = 1'b0;
          brk_nxt_s   = 1'b0;
        end
      end else begin
        push_s = 1'b1;
      end
    end else if (frame_done_s | timeout_s) begin
      ext_nxt_s = 1'b0;
      brk_nxt_s = 1'b0;
    end else begin
      ext_nxt_s = ext_r;
      brk_nxt_s = brk_r;
    end
  end

  // Bit counter, shift register, watchdog, prefix flags and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r    <= 4'd0;
      shift_r      <= 10'd0;
      wd_r         <= '0;
      ext_r        <= 1'b0;
      brk_r        <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      ext_r        <= ext_nxt_s;
      brk_r        <= brk_nxt_s;
      parity_err_r <= frame_done_s & ~framing_bad_s & parity_bad_s;
      frame_err_r  <= (frame_done_s & framing_bad_s) | timeout_s;
      if (fall_s) begin
        wd_r <= '0;
        if (bit_cnt_r == 4'd10) begin
          bit_cnt_r <= 4'd0;
        end else begin
          shift_r   <= {sync_data_s, shift_r[9:1]};
          bit_cnt_r <= bit_cnt_r + 4'd1;
        end
      end else if (timeout_s) begin
        bit_cnt_r <= 4'd0;
        wd_r      <= '0;
      end else if (bit_cnt_r != 4'd0) begin
        wd_r <= wd_r + 1'b1;
      end else begin
        wd_r <= '0;
      end
    end
  end

  // A push while full only lands if a pop frees a slot in the same cycle.
  assign pop_s      = rd_en & (level_r != '0);
  assign do_write_s = push_s & ((level_r != FULL_LVL) | pop_s);

  // FIFO storage carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_write_s) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (do_write_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      if (push_s & ~do_write_s) begin
        overflow_r <= 1'b1;
      end
      case ({do_write_s, pop_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

  assign data       = mem_r[rd_ptr_r];
  assign ready      = (level_r != '0);
  assign full       = (level_r == FULL_LVL);
  assign level      = level_r;
  assign overflow   = overflow_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;

endmodule
